bsg_fifo_rolly_replay_ctrl: RTL and testbench
=============================================

Name: bsg_fifo_rolly_replay_ctrl

Overview:
- Sits directly downstream of the rolly FIFO read port and drives it as a go-back-N retransmit engine toward a lossy link transmitter.
- Streams entries out, tracks sent-but-unacknowledged entries, and commits each in-order ack to the FIFO (r_incr).
- On nack, timeout or error it rewinds the FIFO read pointer to the commit pointer (r_rewind), so every unacked entry is re-sent.

Parameters:
- width_p, (none, must be set), data width; matches the FIFO width_p.
- max_outstanding_p, 8, window size: maximum sent-but-unacked entries; range 1..2^lg_size_p of the FIFO.
- timeout_p, 64, cycles without an ack while outstanding>0 before an automatic rewind; must be >=2.
- backoff_p, 4, idle cycles after a rewind before sending resumes; 0 is legal.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- fifo_data_i  in  width_p  FIFO head data (FIFO data_o).
- fifo_v_i  in  1  FIFO head valid (FIFO v_o).
- fifo_yumi_o  out  1  dequeue: advances the FIFO rptr (FIFO yumi_i).
- fifo_r_incr_o  out  1  commit one acked entry: advances rcptr (FIFO r_incr_i).
- fifo_r_rewind_o  out  1  rptr <= rcptr (FIFO r_rewind_i).
- link_data_o  out  width_p  data to link; equals fifo_data_i.
- link_v_o  out  1  link valid.
- link_ready_i  in  1  link ready; transfer = link_v_o & link_ready_i.
- ack_i  in  1  one in-order ack for the oldest outstanding entry.
- nack_i  in  1  receiver requests retransmit.
- outstanding_o  out  $clog2(max_outstanding_p+1)  current outstanding count.
- error_o  out  1  sticky: an ack arrived with outstanding==0 outside BACKOFF.

Behaviour:
- Reset (asynchronous, while reset_n_i=0):
  - state=SEND; outstanding=0; timer=0; error_o=0.
  - All pulse outputs are 0; link_v_o=0.
- States: SEND, REWIND (exactly 1 cycle), BACKOFF (backoff_p cycles).
- SEND:
  - link_v_o = fifo_v_i & (outstanding < max_outstanding_p). Valid does not depend on ready.
  - fifo_yumi_o = link_v_o & link_ready_i (same cycle, combinational).
- Ack handling:
  - ack_eff = ack_i & outstanding>0 & state!=BACKOFF.
  - fifo_r_incr_o = ack_eff, same cycle.
  - ack_i with outstanding==0 in SEND or REWIND: ignored, and error_o is set.
  - ack_i in BACKOFF: silently dropped.
- Outstanding count:
  - In SEND: outstanding_next = outstanding + fifo_yumi_o - ack_eff. A send and an ack in the same cycle leave the count unchanged.
  - Saturation at max_outstanding_p is prevented by the link_v_o gating, never by wrapping.
- Timer:
  - Cleared when outstanding==0, on ack_eff, or in REWIND/BACKOFF; otherwise increments.
  - Reaching timeout_p-1 triggers a rewind.
- Rewind triggers (in SEND): nack_i, timer expiry, or both. A trigger with outstanding==0 is ignored.
- Trigger cycle: the send is still allowed and ack_eff is still honoured; next state=REWIND.
- REWIND cycle:
  - fifo_r_rewind_o=1; link_v_o=0; fifo_yumi_o=0.
  - ack_eff may also pulse fifo_r_incr_o; the FIFO supports incr+rewind together, and rptr lands on rcptr+1.
  - outstanding_next=0.
  - Next state is BACKOFF if backoff_p>0, else SEND.
- BACKOFF: link_v_o=0; nack_i ignored; a counter runs backoff_p cycles, then state returns to SEND.
- nack_i in REWIND or BACKOFF is ignored; no queued rewind.
- FIFO empty (fifo_v_i=0): no send; timer still runs while outstanding>0.
- Reset mid-rewind: outstanding is cleared, but the FIFO's rptr is not restored by this block. The FIFO shares the reset, so system reset covers both.

Optional Feature:
- Macro: BSG_FIFO_ROLLY_REPLAY_STATS_EN.
- Defined: adds output replay_count_o [15:0]. It increments by 1 on each REWIND cycle, saturates at 16'hFFFF, and is reset to 0.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Steady stream, max_outstanding_p=8, link_ready_i=1, ack_i held 0, 20 entries queued -> exactly 8 transfers, then link_v_o=0 with outstanding_o=8; each later ack_i pulse releases exactly 1 further transfer.
- 3 entries sent (D0..D2), nack_i=1 on cycle t -> fifo_r_rewind_o=1 at t+1; link_v_o=0 for 4 cycles (backoff_p=4); D0 re-sent at t+6.
- Ack and send in the same cycle at outstanding=5 -> outstanding_o stays 5; fifo_r_incr_o=1 and fifo_yumi_o=1 together.
- 1 entry outstanding, no ack, timeout_p=64 -> rewind pulse exactly 64 cycles after the send; no rewind when outstanding=0 for 200 cycles.
- ack_i with outstanding=0 in SEND -> fifo_r_incr_o=0 and error_o=1 (sticky); ack_i during BACKOFF -> dropped, error_o unchanged.
- Async reset asserted in BACKOFF, mid-cycle -> outputs are 0 immediately without waiting for a clock edge; after release, state=SEND and outstanding_o=0.

Source files
------------

// File: rtl/bsg_fifo_rolly_replay_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : bsg_fifo_rolly_replay_ctrl_if
// Brief    : FIFO read-port and lossy-link handshake bundle for the replay
//            controller. The master view is the controller itself.
// Revision : 1.0 - initial release
// ============================================================================
interface bsg_fifo_rolly_replay_ctrl_if #(
    parameter int width_p = 8
);
    logic [width_p-1:0] fifo_data_i;
    logic               fifo_v_i;
    logic               fifo_yumi_o;
    logic               fifo_r_incr_o;
    logic               fifo_r_rewind_o;
    logic [width_p-1:0] link_data_o;
    logic               link_v_o;
    logic               link_ready_i;
    logic               ack_i;
    logic               nack_i;

    modport master (
        input  fifo_data_i, fifo_v_i, link_ready_i, ack_i, nack_i,
        output fifo_yumi_o, fifo_r_incr_o, fifo_r_rewind_o, link_data_o, link_v_o
    );

    modport slave (
        output fifo_data_i, fifo_v_i, link_ready_i, ack_i, nack_i,
        input  fifo_yumi_o, fifo_r_incr_o, fifo_r_rewind_o, link_data_o, link_v_o
    );
endinterface
`default_nettype wire

// File: rtl/bsg_fifo_rolly_replay_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bsg_fifo_rolly_replay_ctrl
// Brief    : Go-back-N retransmit engine driving a rolly FIFO read port.
//            Optional replay counter: define BSG_FIFO_ROLLY_REPLAY_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bsg_fifo_rolly_replay_ctrl #(
    parameter int width_p           = 8,
    parameter int max_outstanding_p = 8,
    parameter int timeout_p         = 64,
    parameter int backoff_p         = 4
) (
    input  wire logic                                   clk_i,
    input  wire logic                                   reset_n_i,
    bsg_fifo_rolly_replay_ctrl_if.master                bus,
    output logic [$clog2(max_outstanding_p+1)-1:0]      outstanding_o,
    output logic                                        error_o
`ifdef BSG_FIFO_ROLLY_REPLAY_STATS_EN
    ,
    output logic [15:0]                                 replay_count_o
`endif
);

    localparam int c_out_w = $clog2(max_outstanding_p + 1);
    localparam int c_tmr_w = (timeout_p > 2) ? $clog2(timeout_p) : 1;
    localparam int c_bo_w  = (backoff_p > 1) ? $clog2(backoff_p) : 1;

    localparam logic [c_out_w-1:0] c_max_out  = c_out_w'(max_outstanding_p);
    localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(timeout_p - 2);
    localparam logic [c_bo_w-1:0]  c_bo_last  = c_bo_w'((backoff_p > 0) ? backoff_p - 1 : 0);

    typedef enum logic [1:0] {
        ST_SEND    = 2'd0,
        ST_REWIND  = 2'd1,
        ST_BACKOFF = 2'd2
    } state_e;

    state_e               r_state;
    logic [c_out_w-1:0]   r_outstanding;
    logic [c_tmr_w-1:0]   r_timer;
    logic [c_bo_w-1:0]    r_bo_cnt;
    logic                 r_error;

    logic w_in_send;
    logic w_busy;
    logic w_link_v;
    logic w_xfer;
    logic w_ack_eff;
    logic w_ack_err;
    logic w_expire;
    logic w_trigger;

    assign w_in_send = (r_state == ST_SEND);
    assign w_busy    = (r_outstanding != '0);
    assign w_link_v  = w_in_send & bus.fifo_v_i & (r_outstanding < c_max_out);
    assign w_xfer    = w_link_v & bus.link_ready_i;
    assign w_ack_eff = bus.ack_i & w_busy & (r_state != ST_BACKOFF);
    assign w_ack_err = bus.ack_i & ~w_busy & (r_state != ST_BACKOFF);

    // Expiry fires on the cycle the timer would step onto timeout_p-1, so the
    // rewind lands exactly timeout_p cycles after the last progress event.
    assign w_expire  = w_in_send & w_busy & ~w_ack_eff & (r_timer == c_tmr_last);
    assign w_trigger = w_in_send & w_busy & (bus.nack_i | w_expire);

    // The FIFO head may be valid during reset; keep the link quiet regardless.
    assign bus.link_v_o        = w_link_v & reset_n_i;
    assign bus.fifo_yumi_o     = w_xfer & reset_n_i;
    assign bus.fifo_r_incr_o   = w_ack_eff;
    assign bus.fifo_r_rewind_o = (r_state == ST_REWIND);
    assign bus.link_data_o     = bus.fifo_data_i;
    assign outstanding_o       = r_outstanding;
    assign error_o             = r_error;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state       <= ST_SEND;
            r_outstanding <= '0;
            r_timer       <= '0;
            r_bo_cnt      <= '0;
            r_error       <= 1'b0;
        end else begin
            if (w_ack_err) begin
                r_error <= 1'b1;
            end
            case (r_state)
                ST_SEND: begin
                    r_outstanding <= r_outstanding + c_out_w'(w_xfer) - c_out_w'(w_ack_eff);
                    if (w_trigger) begin
                        r_state <= ST_REWIND;
                        r_timer <= '0;
                    end else if (!w_busy || w_ack_eff) begin
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + c_tmr_w'(1);
                    end
                end
                ST_REWIND: begin
                    r_outstanding <= '0;
                    r_timer       <= '0;
                    r_bo_cnt      <= '0;
                    r_state       <= (backoff_p > 0) ? ST_BACKOFF : ST_SEND;
                end
                ST_BACKOFF: begin
                    r_timer <= '0;
                    if (r_bo_cnt == c_bo_last) begin
                        r_bo_cnt <= '0;
                        r_state  <= ST_SEND;
                    end else begin
                        r_bo_cnt <= r_bo_cnt + c_bo_w'(1);
                    end
                end
                default: begin
                    r_state <= ST_SEND;
                end
            endcase
        end
    end

`ifdef BSG_FIFO_ROLLY_REPLAY_STATS_EN
    logic [15:0] r_replay_count;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_replay_count <= '0;
        end else if ((r_state == ST_REWIND) && (r_replay_count != 16'hFFFF)) begin
            r_replay_count <= r_replay_count + 16'd1;
        end
    end

    assign replay_count_o = r_replay_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bsg_fifo_rolly_replay_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsg_fifo_rolly_replay_ctrl
// Brief    : Randomized scoreboard bench with a go-back-N reference model and
//            a rolly FIFO environment model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bsg_fifo_rolly_replay_ctrl;

    localparam int W    = 16;
    localparam int MAXO = 8;
    localparam int TO   = 64;
    localparam int BO   = 4;
    localparam int OW   = $clog2(MAXO + 1);

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    bsg_fifo_rolly_replay_ctrl_if #(.width_p(W)) bus ();
    logic [OW-1:0] outstanding;
    logic          error;
`ifdef BSG_FIFO_ROLLY_REPLAY_STATS_EN
    logic [15:0]   replay_count;
`endif

    bsg_fifo_rolly_replay_ctrl #(
        .width_p           (W),
        .max_outstanding_p (MAXO),
        .timeout_p         (TO),
        .backoff_p         (BO)
    ) dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n),
        .bus           (bus),
        .outstanding_o (outstanding),
        .error_o       (error)
`ifdef BSG_FIFO_ROLLY_REPLAY_STATS_EN
        ,
        .replay_count_o(replay_count)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- rolly FIFO environment ----------------
    int rptr = 0, rcptr = 0, wptr = 0;
    logic cap_yumi = 1'b0, cap_incr = 1'b0, cap_rew = 1'b0;

    function automatic logic [W-1:0] entry(input int idx);
        return W'(idx * 40503 + 17);
    endfunction

    assign bus.fifo_v_i    = (rptr < wptr);
    assign bus.fifo_data_i = entry(rptr);

    always @(negedge clk) begin
        cap_yumi <= bus.fifo_yumi_o;
        cap_incr <= bus.fifo_r_incr_o;
        cap_rew  <= bus.fifo_r_rewind_o;
    end

    always @(posedge clk) begin
        if (reset_n) begin
            if (cap_rew)       rptr <= rcptr + (cap_incr ? 1 : 0);
            else if (cap_yumi) rptr <= rptr + 1;
            if (cap_incr)      rcptr <= rcptr + 1;
        end
    end

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        logic          v, yumi, incr, rew, err;
        int            outs;
        logic [W-1:0]  data;
    } exp_t;
    exp_t sbq[$];

    int m_mode;      // 0 sending, 1 rewinding, 2 backing off
    int m_outs, m_sent, m_commit, m_quiet, m_bo_left;
    bit m_err;

    task automatic model_init();
        m_mode = 0; m_outs = 0; m_sent = 0; m_commit = 0;
        m_quiet = 0; m_bo_left = 0; m_err = 1'b0;
    endtask

    always @(posedge clk) begin : model_p
        exp_t e;
        bit   ack_eff, trig;
        #2;
        if (reset_n) begin
            e.v     = (m_mode == 0) && (m_sent < wptr) && (m_outs < MAXO);
            e.yumi  = e.v && bus.link_ready_i;
            ack_eff = bus.ack_i && (m_outs > 0) && (m_mode != 2);
            e.incr  = ack_eff;
            e.rew   = (m_mode == 1);
            e.outs  = m_outs;
            e.err   = m_err;
            e.data  = entry(m_sent);
            sbq.push_back(e);

            if (bus.ack_i && m_outs == 0 && m_mode != 2) m_err = 1'b1;
            m_quiet = (m_mode == 0 && m_outs > 0 && !ack_eff) ? m_quiet + 1 : 0;
            trig    = (m_mode == 0) && (m_outs > 0) && (bus.nack_i || m_quiet == TO - 1);
            case (m_mode)
                0: begin
                    m_outs   += int'(e.yumi) - int'(ack_eff);
                    m_sent   += int'(e.yumi);
                    m_commit += int'(ack_eff);
                    if (trig) m_mode = 1;
                end
                1: begin
                    m_commit += int'(ack_eff);
                    m_sent    = m_commit;
                    m_outs    = 0;
                    if (BO > 0) begin m_mode = 2; m_bo_left = BO; end
                    else m_mode = 0;
                end
                default: begin
                    m_bo_left--;
                    if (m_bo_left == 0) m_mode = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin : monitor_p
        exp_t e;
        if (reset_n && sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("link_v",      bus.link_v_o,        e.v);
            chk("fifo_yumi",   bus.fifo_yumi_o,     e.yumi);
            chk("r_incr",      bus.fifo_r_incr_o,   e.incr);
            chk("r_rewind",    bus.fifo_r_rewind_o, e.rew);
            chk("outstanding", outstanding,         e.outs);
            chk("error",       error,               e.err);
            if (e.v) chk("link_data", bus.link_data_o, e.data);
        end
    end

    // ---------------- stimulus ----------------
    int p_ready, p_ack, p_nack, p_enq, enq_max;

    task automatic knobs(input int r, input int a, input int n, input int q, input int qm);
        p_ready = r; p_ack = a; p_nack = n; p_enq = q; enq_max = qm;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        bus.link_ready_i = (int'($urandom_range(99)) < p_ready);
        bus.ack_i        = (int'($urandom_range(99)) < p_ack);
        bus.nack_i       = (int'($urandom_range(99)) < p_nack);
        if (int'($urandom_range(99)) < p_enq) wptr += int'($urandom_range(enq_max, 1));
    endtask

    // Entered at +1 after a clock edge; asserts reset mid-cycle and checks
    // that outputs clear without any clock edge.
    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        sbq.delete();
        model_init();
        rptr = 0; rcptr = 0; wptr = 3;
        bus.ack_i = 1'b1; bus.nack_i = 1'b1; bus.link_ready_i = 1'b1;
        #1;
        chk("rst_link_v",      bus.link_v_o,        1'b0);
        chk("rst_yumi",        bus.fifo_yumi_o,     1'b0);
        chk("rst_r_incr",      bus.fifo_r_incr_o,   1'b0);
        chk("rst_r_rewind",    bus.fifo_r_rewind_o, 1'b0);
        chk("rst_outstanding", outstanding,         '0);
        chk("rst_error",       error,               1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_link_v", bus.link_v_o, 1'b0);
        bus.ack_i = 1'b0; bus.nack_i = 1'b0; bus.link_ready_i = 1'b0;
        wptr = 0;
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_outstanding", outstanding,  '0);
        chk("post_rst_link_v",      bus.link_v_o, 1'b0);
    endtask

    task automatic mid_reset(input int kind);
        bit hit = 1'b0;
        for (int i = 0; i < 3000 && !hit; i++) begin
            step();
            if (kind == 0) hit = bus.fifo_r_rewind_o;
            else           hit = (outstanding != '0);
        end
        chk("mid_reset_reached", hit, 1'b1);
        if (kind == 0 && hit) step();
        do_reset();
    endtask

    initial begin
        bus.link_ready_i = 1'b0;
        bus.ack_i        = 1'b0;
        bus.nack_i       = 1'b0;
        model_init();
        knobs(0, 0, 0, 0, 1);
        #1;
        do_reset();

        // window fill: 20 queued, no acks, then sparse acks release one each
        knobs(100, 0, 0, 0, 1);
        wptr = 20;
        repeat (40) step();
        knobs(100, 15, 0, 0, 1);
        repeat (80) step();

        knobs(70, 25, 3, 40, 3);
        repeat (2000) step();

        // ack storm on a draining FIFO, then a single entry left to time out
        knobs(100, 50, 0, 0, 1);
        repeat (200) step();
        knobs(100, 100, 0, 0, 1);
        repeat (100) step();
        knobs(100, 0, 0, 0, 1);
        wptr += 1;
        repeat (150) step();
        knobs(100, 100, 0, 0, 1);
        repeat (20) step();
        knobs(100, 0, 0, 0, 1);
        repeat (200) step();

        knobs(80, 20, 10, 50, 2);
        mid_reset(0);
        knobs(70, 25, 3, 40, 3);
        repeat (500) step();
        knobs(100, 0, 0, 60, 2);
        mid_reset(1);
        knobs(60, 30, 5, 40, 3);
        repeat (500) step();

        @(posedge clk);
        #6;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
